rx_deframer: RTL and testbench

Receive-side partner of the transmit bit stuffer. It recovers bit timing from RX using the programmed baud divisor and hunts for 0x7E flags. It removes stuffed zeros, assembles LSB-first bytes into a one-byte holding register and raises status bits for the CPU status register and interrupt logic.

---
 rtl/rx_deframer.sv | 165 ++++++++++++++++
 tb/tb_rx_deframer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - HDLC-style receive deframer: bit timing, flag hunt, destuffing, byte holding register
module rx_deframer (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       EN,
  input  logic [7:0] BAUD,
  input  logic       RX,
  input  logic       RD,
  input  logic       CLR,
  output logic [7:0] DOUT,
  output logic       RXRDY,
  output logic       FIRST,
  output logic       ENDFRAME,
  output logic       FRAMEERR,
  output logic       ABORT,
  output logic       OVERRUN
);

  typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

  logic       sync1_q, sync2_q, sync3_q;
  logic [7:0] cnt_q;
  logic       rx_bit, rx_edge, tick;

  state_t     state_q;
  logic [2:0] bitcnt_q;
  logic [6:0] shreg_q;
  logic [2:0] ones_q, ones_d;
  logic [7:0] dout_q;
  logic       rxrdy_q, first_q, end_q, ferr_q, abort_q, ovr_q;

  logic       is_data, is_flag, is_abort;
  logic       commit, accept;
  logic [7:0] byte_new;
  logic       set_end, set_ferr, set_abort, set_ovr;

  // RX synchronizer plus one extra stage for edge detection; idles high
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx_bit  = sync2_q;
  assign rx_edge = sync2_q ^ sync3_q;

  // Bit-period down counter, re-centred on every line edge
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      cnt_q <= 8'd0;
    end else if (!EN) begin
      cnt_q <= BAUD;
    end else if (rx_edge) begin
      cnt_q <= BAUD >> 1;
    end else if (cnt_q == 8'd0) begin
      cnt_q <= BAUD;
    end else begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // An edge restarts the half-bit count, so a coincident expiry would sample the
  // new bit twice; at BAUD=0 each cycle is its own bit and must always tick.
  assign tick = EN && (cnt_q == 8'd0) && (!rx_edge || (BAUD == 8'd0));

  // Classify each sampled bit by the run of ones preceding it
  always_comb begin
    is_data  = 1'b0;
    is_flag  = 1'b0;
    is_abort = 1'b0;
    ones_d   = ones_q;
    if (tick) begin
      if (ones_q < 3'd5) begin
        is_data = 1'b1;
        ones_d  = rx_bit ? ones_q + 3'd1 : 3'd0;
      end else if (ones_q == 3'd5) begin
        ones_d = rx_bit ? 3'd6 : 3'd0;
      end else if (ones_q == 3'd6) begin
        is_abort = rx_bit;
        is_flag  = !rx_bit;
        ones_d   = rx_bit ? 3'd7 : 3'd0;
      end else begin
        ones_d = rx_bit ? 3'd7 : 3'd0;
      end
    end
    if (!EN) begin
      ones_d = 3'd0;
    end
  end

  // Byte completion and status events derived from the classified bit
  always_comb begin
    byte_new  = {rx_bit, shreg_q};
    commit    = is_data && (state_q != HUNT) && (bitcnt_q == 3'd7);
    accept    = commit && (!rxrdy_q || RD);
    set_end   = is_flag && (state_q == DATA) && (bitcnt_q == 3'd6);
    set_ferr  = is_flag && (state_q == DATA) && (bitcnt_q != 3'd6);
    set_abort = is_abort && (state_q != HUNT);
    set_ovr   = commit && rxrdy_q && !RD;
  end

  // Framing FSM with byte assembly, holding register and sticky status
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= HUNT;
      bitcnt_q <= 3'd0;
      shreg_q  <= 7'd0;
      ones_q   <= 3'd0;
      dout_q   <= 8'h00;
      rxrdy_q  <= 1'b0;
      first_q  <= 1'b0;
      end_q    <= 1'b0;
      ferr_q   <= 1'b0;
      abort_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ones_q <= ones_d;

      if (!EN) begin
        state_q  <= HUNT;
        bitcnt_q <= 3'd0;
      end else if (is_flag) begin
        state_q  <= SYNC;
        bitcnt_q <= 3'd0;
      end else if (is_abort) begin
        state_q  <= HUNT;
        bitcnt_q <= 3'd0;
      end else if (is_data && (state_q != HUNT)) begin
        shreg_q  <= byte_new[7:1];
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          state_q <= DATA;
        end
      end

      if (accept) begin
        dout_q  <= byte_new;
        first_q <= (state_q == SYNC);
        rxrdy_q <= 1'b1;
      end else if (RD) begin
        rxrdy_q <= 1'b0;
      end

      end_q   <= set_end   | (end_q   & !CLR);
      ferr_q  <= set_ferr  | (ferr_q  & !CLR);
      abort_q <= set_abort | (abort_q & !CLR);
      ovr_q   <= set_ovr   | (ovr_q   & !CLR);
    end
  end

  assign DOUT     = dout_q;
  assign RXRDY    = rxrdy_q;
  assign FIRST    = first_q;
  assign ENDFRAME = end_q;
  assign FRAMEERR = ferr_q;
  assign ABORT    = abort_q;
  assign OVERRUN  = ovr_q;

endmodule

// File: tb/tb_rx_deframer.sv
// tb/tb_rx_deframer.sv - self-checking bench for rx_deframer
module tb_rx_deframer;

  logic       clk = 1'b0;
  logic       nrst, en, rx, clr;
  logic [7:0] baud;
  logic       rd;
  logic [7:0] dout;
  logic       rxrdy, first, endframe, frameerr, abort_o, overrun;

  logic rd_auto = 1'b0;
  logic rd_man  = 1'b0;
  assign rd = rd_auto | rd_man;

  always #5 clk = ~clk;

  rx_deframer dut (
    .CLK(clk), .NRST(nrst), .EN(en), .BAUD(baud), .RX(rx), .RD(rd), .CLR(clr),
    .DOUT(dout), .RXRDY(rxrdy), .FIRST(first), .ENDFRAME(endframe),
    .FRAMEERR(frameerr), .ABORT(abort_o), .OVERRUN(overrun)
  );

  int n_err = 0;
  int n_chk = 0;
  int P = 4;
  int tx_ones = 0;
  bit mon_en = 1'b0;
  logic [8:0] got[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CPU-side reader: captures {FIRST,DOUT} and acknowledges with a one-cycle RD
  always @(negedge clk) begin
    if (rd_auto) rd_auto = 1'b0;
    else if (mon_en && rxrdy) begin
      got.push_back({first, dout});
      rd_auto = 1'b1;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bitout(input logic b);
    rx = b;
    wait_n(P);
  endtask

  task automatic idle(input int n);
    repeat (n) bitout(1'b1);
    tx_ones = 0;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) bitout(f[i]);
    tx_ones = 0;
  endtask

  // Transmit-side stuffer: a zero follows every five consecutive data ones
  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      bitout(d[i]);
      if (d[i]) tx_ones++; else tx_ones = 0;
      if (tx_ones == 5) begin
        bitout(1'b0);
        tx_ones = 0;
      end
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    wait_n(1);
    clr = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input int nb, input logic [31:0] d,
                           input int extra_n, input logic [7:0] xb, input logic ab);
    baud = b;
    P = int'(b) + 1;
    idle(12);
    pulse_clr();
    got.delete();
    send_flag();
    send_flag();
    for (int k = 0; k < nb; k++) send_byte(d[8*k +: 8]);
    for (int i = 0; i < extra_n; i++) bitout(xb[i]);
    if (ab) repeat (7) bitout(1'b1);
    send_flag();
    idle(2);
  endtask

  typedef struct packed {
    logic [7:0]  baud;
    logic [2:0]  nb;
    logic [31:0] d;
    logic [2:0]  extra_n;
    logic [7:0]  extra_bits;
    logic        abort_end;
    logic [2:0]  n_exp;
    logic [44:0] e;
    logic        exp_end;
    logic        exp_ferr;
    logic        exp_abort;
  } vec_t;

  vec_t vecs[6];
  logic [8:0] expq[$];

  initial begin
    vecs[0] = '{8'd3, 3'd2, 32'h0000_4241, 3'd0, 8'h00, 1'b0, 3'd2, {27'd0, 9'h042, 9'h141}, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'd3, 3'd2, 32'h0000_1FFF, 3'd0, 8'h00, 1'b0, 3'd2, {27'd0, 9'h01F, 9'h1FF}, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'd3, 3'd1, 32'h0000_0055, 3'd0, 8'h00, 1'b1, 3'd1, {36'd0, 9'h155},          1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'd3, 3'd1, 32'h0000_0033, 3'd3, 8'h05, 1'b0, 3'd2, {27'd0, 9'h0F5, 9'h133}, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'd0, 3'd3, 32'h007E_00A5, 3'd0, 8'h00, 1'b0, 3'd3, {18'd0, 9'h07E, 9'h000, 9'h1A5}, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'd7, 3'd2, 32'h0000_81C3, 3'd0, 8'h00, 1'b0, 3'd2, {27'd0, 9'h081, 9'h1C3}, 1'b1, 1'b0, 1'b0};

    nrst = 1'b0; en = 1'b1; rx = 1'b1; clr = 1'b0; baud = 8'd3;
    wait_n(3);
    check("reset_outputs", {dout, rxrdy, first, endframe, frameerr, abort_o, overrun}, 64'd0);
    nrst = 1'b1;
    mon_en = 1'b1;

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].baud, int'(vecs[v].nb), vecs[v].d, int'(vecs[v].extra_n),
                vecs[v].extra_bits, vecs[v].abort_end);
      check("vec_nbytes", got.size(), vecs[v].n_exp);
      for (int i = 0; i < int'(vecs[v].n_exp) && i < got.size(); i++)
        check("vec_byte", got[i], vecs[v].e[9*i +: 9]);
      check("vec_endframe", endframe, vecs[v].exp_end);
      check("vec_frameerr", frameerr, vecs[v].exp_ferr);
      check("vec_abort", abort_o, vecs[v].exp_abort);
      check("vec_overrun", overrun, 1'b0);
      if (v == 3) begin
        pulse_clr();
        check("clr_frameerr", frameerr, 1'b0);
      end
    end

    // Reset in the middle of a byte, then unflagged bytes are ignored
    baud = 8'd3; P = 4;
    idle(10);
    send_flag();
    for (int i = 0; i < 4; i++) bitout(i[0]);
    nrst = 1'b0;
    #1;
    check("midreset_outputs", {dout, rxrdy, first, endframe, frameerr, abort_o, overrun}, 64'd0);
    wait_n(2);
    nrst = 1'b1;
    got.delete();
    send_byte(8'h12);
    send_byte(8'h34);
    idle(2);
    check("noflag_ignored", got.size(), 0);
    send_flag();
    send_byte(8'h56);
    send_flag();
    idle(2);
    check("postreset_nbytes", got.size(), 1);
    if (got.size() > 0) check("postreset_byte", got[0], 9'h156);
    check("postreset_endframe", endframe, 1'b1);

    // Overrun, CLR coincident with a set, and RD coincident with a commit
    mon_en = 1'b0;
    idle(12);
    pulse_clr();
    send_flag();
    fork
      begin
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_flag();
      end
      begin
        int t;
        t = 0;
        while (!overrun && t < 2000) begin
          wait_n(1);
          t++;
        end
        check("ovr_seen", overrun, 1'b1);
        if (overrun) begin
          check("ovr_dout_kept", dout, 8'h11);
          check("ovr_rxrdy", rxrdy, 1'b1);
          clr = 1'b1;
          wait_n(1);
          clr = 1'b0;
          check("ovr_cleared", overrun, 1'b0);
          wait_n(8 * P - 2);
          clr = 1'b1;
          wait_n(1);
          check("set_beats_clr", overrun, 1'b1);
          check("ovr2_dout_kept", dout, 8'h11);
          wait_n(1);
          clr = 1'b0;
          check("ovr_cleared2", overrun, 1'b0);
          wait_n(8 * P - 2);
          rd_man = 1'b1;
          wait_n(1);
          rd_man = 1'b0;
          check("rd_commit_dout", dout, 8'h44);
          check("rd_commit_rxrdy", rxrdy, 1'b1);
          check("rd_commit_no_ovr", overrun, 1'b0);
          check("rd_commit_first", first, 1'b0);
        end
      end
    join
    idle(2);
    check("ovr_endframe", endframe, 1'b1);
    mon_en = 1'b1;
    wait_n(4);

    // Randomized well-formed frames against the frame-level reference
    for (int f = 0; f < 16; f++) begin
      logic [7:0]  rb;
      logic [31:0] rd_data;
      int          nb;
      case ($urandom_range(0, 4))
        0: rb = 8'd0;
        1: rb = 8'd1;
        2: rb = 8'd2;
        3: rb = 8'd3;
        default: rb = 8'd5;
      endcase
      nb = $urandom_range(1, 4);
      rd_data = $urandom;
      expq.delete();
      for (int k = 0; k < nb; k++) expq.push_back({(k == 0), rd_data[8*k +: 8]});
      run_frame(rb, nb, rd_data, 0, 8'h00, 1'b0);
      check("rnd_nbytes", got.size(), expq.size());
      for (int i = 0; i < expq.size() && i < got.size(); i++)
        check("rnd_byte", got[i], expq[i]);
      check("rnd_status", {endframe, frameerr, abort_o, overrun}, 4'b1000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
